// File: rtl/cmp_arb_32.sv
// cmp_arb_32: two requesters share one subtract-based less-than comparator behind a round-robin arbiter.
// Optional macro CMP_SIGNED_EN: when defined, REQn_SIGNED selects a signed compare; otherwise every compare is unsigned.
module cmp_arb_32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ0_SIGNED,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic             REQ1_SIGNED,
  output logic             REQ1_READY,
  output logic             RSP_VALID,
  output logic             RSP_ID,
  output logic             RSP_LT,
  input  logic             RSP_READY,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             pri_r;
  logic             id_r;
  logic             rsp_id_r;
  logic             rsp_lt_r;
  logic             rsp_valid_r;
  logic             busy_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             grant0_s;
  logic             grant1_s;
  logic [WIDTH:0]   diff_s;
  logic             lt_s;

`ifdef CMP_SIGNED_EN
  logic             sgn_r;
`else
  logic             unused_signed_s;
  assign unused_signed_s = REQ0_SIGNED ^ REQ1_SIGNED;
`endif

  // Signed compare: differing sign bits decide directly, otherwise the low-half borrow does.
  function automatic logic lt_from_diff(input logic [WIDTH:0] d, input logic a_msb,
                                        input logic b_msb, input logic sgn);
    logic lt;
    if (sgn && (a_msb != b_msb)) begin
      lt = a_msb;
    end else if (sgn) begin
      lt = d[WIDTH-1];
    end else begin
      lt = d[WIDTH];
    end
    return lt;
  endfunction

  // Arbitration: a lone requester wins, contention is resolved by the priority pointer.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (REQ0_VALID && REQ1_VALID) begin
        grant0_s = ~pri_r;
        grant1_s = pri_r;
      end else begin
        grant0_s = REQ0_VALID;
        grant1_s = REQ1_VALID;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Shared comparator on the latched operands.
  always_comb begin
    diff_s = {1'b0, a_r} - {1'b0, b_r};
`ifdef CMP_SIGNED_EN
    lt_s   = lt_from_diff(diff_s, a_r[WIDTH-1], b_r[WIDTH-1], sgn_r);
`else
    lt_s   = lt_from_diff(diff_s, a_r[WIDTH-1], b_r[WIDTH-1], 1'b0);
`endif
  end

  // Control FSM with operand capture and registered response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      pri_r       <= 1'b0;
      id_r        <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_lt_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
`ifdef CMP_SIGNED_EN
      sgn_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            a_r     <= grant1_s ? REQ1_A : REQ0_A;
            b_r     <= grant1_s ? REQ1_B : REQ0_B;
`ifdef CMP_SIGNED_EN
            sgn_r   <= grant1_s ? REQ1_SIGNED : REQ0_SIGNED;
`endif
            id_r    <= grant1_s;
            pri_r   <= ~grant1_s;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end
        end
        CALC: begin
          rsp_lt_r    <= lt_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign REQ0_READY = grant0_s;
  assign REQ1_READY = grant1_s;
  assign RSP_VALID  = rsp_valid_r;
  assign RSP_ID     = rsp_id_r;
  assign RSP_LT     = rsp_lt_r;
  assign BUSY       = busy_r;

endmodule

// File: tb/tb_cmp_arb_32.sv
// Self-checking bench for cmp_arb_32: directed vector table, hand-written corner sequences, random traffic.
module tb_cmp_arb_32;

`ifdef CMP_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_signed, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_signed, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_lt, rsp_ready, busy;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic model_pri = 1'b0;

  cmp_arb_32 #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(req0_valid), .REQ0_A(req0_a), .REQ0_B(req0_b),
    .REQ0_SIGNED(req0_signed), .REQ0_READY(req0_ready),
    .REQ1_VALID(req1_valid), .REQ1_A(req1_a), .REQ1_B(req1_b),
    .REQ1_SIGNED(req1_signed), .REQ1_READY(req1_ready),
    .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_LT(rsp_lt),
    .RSP_READY(rsp_ready), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        exp_id;
    logic        exp_lt;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain arithmetic less-than in the requested mode.
  function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (SEN && s) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; ends one cycle into the following IDLE.
  task automatic run_gen(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic s0, input logic s1, input int stall,
                         input logic eid, input logic elt, input string tag);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_signed = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_signed = s1;
    rsp_ready  = (stall == 0);
    #1;
    chk({tag, "_ready0"}, req0_ready, !eid);
    chk({tag, "_ready1"}, req1_ready, eid);
    step();
    model_pri  = ~eid;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    #1;
    chk({tag, "_calc_rspvalid"}, rsp_valid, 0);
    chk({tag, "_calc_busy"}, busy, 1);
    step();
    chk({tag, "_rspvalid"}, rsp_valid, 1);
    chk({tag, "_rspid"}, rsp_id, eid);
    chk({tag, "_rsplt"}, rsp_lt, elt);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_lt"}, rsp_lt, elt);
    end
    rsp_ready = 1'b1;
    step();
    chk({tag, "_done_valid"}, rsp_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_retain_lt"}, rsp_lt, elt);
    chk({tag, "_retain_id"}, rsp_id, eid);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_pri = 1'b0;
  endtask

  initial begin
    int   hs_n, rs_n;
    int   hcyc[4];
    logic gid[4];
    logic rid[4];
    logic [31:0] ca0, cb0, ca1, cb1;

    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_signed = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_signed = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_rspvalid", rsp_valid, 0);
    chk("reset_rspid", rsp_id, 0);
    chk("reset_rsplt", rsp_lt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready0", req0_ready, 0);
    chk("reset_ready1", req1_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    vt[0] = '{1'b1, 1'b0, 32'd5,        32'd7,        1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 32'd7,        32'd5,        1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b1, SEN};
    vt[4] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, SEN};
    vt[6] = '{1'b0, 1'b1, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_gen(vt[i].v0, vt[i].v1, vt[i].a, vt[i].b, vt[i].a, vt[i].b,
              vt[i].s, vt[i].s, 0, vt[i].exp_id, vt[i].exp_lt, $sformatf("vec%0d", i));
    end

    // Contention from reset: grants and responses must alternate 0,1,0,1 every 3 cycles.
    do_reset();
    ca0 = $urandom; cb0 = $urandom; ca1 = $urandom; cb1 = $urandom;
    req0_a = ca0; req0_b = cb0; req1_a = ca1; req1_b = cb1;
    req0_signed = 1'b0; req1_signed = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    hs_n = 0; rs_n = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (req0_ready && req1_ready) chk("cont_one_ready", 1, 0);
      if ((req0_ready || req1_ready) && hs_n < 4) begin
        gid[hs_n] = req1_ready; hcyc[hs_n] = cyc; hs_n++;
      end
      if (rsp_valid && rs_n < 4) begin
        rid[rs_n] = rsp_id;
        chk("cont_lt", rsp_lt, rsp_id ? model_lt(ca1, cb1, 1'b1) : model_lt(ca0, cb0, 1'b0));
        rs_n++;
      end
      if (cyc < 11) step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_hs_count", hs_n, 4);
    chk("cont_rsp_count", rs_n, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_n) chk($sformatf("cont_grant%0d", i), gid[i], i % 2);
      if (i < rs_n) chk($sformatf("cont_rspid%0d", i), rid[i], i % 2);
      if (i > 0 && i < hs_n) chk($sformatf("cont_spacing%0d", i), hcyc[i] - hcyc[i-1], 3);
    end
    step();
    model_pri = 1'b0;

    // Backpressure: response held for 5 cycles while a new request waits.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd9; req0_signed = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", req0_ready, 1);
    step();
    step();
    chk("bp_rspvalid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_lt", rsp_lt, 1);
      chk("bp_ready0_low", req0_ready, 0);
      chk("bp_ready1_low", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_next_ready0", req0_ready, 1);
    req0_valid = 1'b0;
    model_pri = 1'b1;
    #1;

    // Reset during CALC: drop the transaction and clear the priority pointer.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
    step();
    req0_valid = 1'b0;
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_valid", rsp_valid, 0);
    step();
    step();
    chk("rst_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    model_pri = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_pri_ready0", req0_ready, 1);
    chk("rst_pri_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    run_gen(1'b0, 1'b1, 32'd0, 32'd0, 32'h10, 32'h20, 1'b0, 1'b0, 0, 1'b1, 1'b1, "rst_req1");

    // Idle stability: pointer must survive 10 quiet cycles.
    run_gen(1'b1, 1'b0, 32'd9, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "pre_idle");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_busy", busy, 0);
      chk("idle_rspvalid", rsp_valid, 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("idle_pri_ready1", req1_ready, model_pri);
    chk("idle_pri_ready0", req0_ready, !model_pri);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  v;
      logic [31:0] ra0, rb0, ra1, rb1;
      logic        rs0, rs1, eid, elt;
      v   = 2'($urandom_range(1, 3));
      ra0 = $urandom; rb0 = ($urandom_range(0, 4) == 0) ? ra0 : $urandom;
      ra1 = $urandom; rb1 = ($urandom_range(0, 4) == 0) ? ra1 : $urandom;
      rs0 = 1'($urandom_range(0, 1)); rs1 = 1'($urandom_range(0, 1));
      eid = (v[0] && v[1]) ? model_pri : v[1];
      elt = eid ? model_lt(ra1, rb1, rs1) : model_lt(ra0, rb0, rs0);
      run_gen(v[0], v[1], ra0, rb0, ra1, rb1, rs0, rs1, int'($urandom_range(0, 2)),
              eid, elt, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
